// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - synchronous FIFO controller around an external dual-port RAM
// Port A writes at wr_ptr, port B reads at rd_ptr with one clock of RAM read latency.
module fifo_ctrl #(
  parameter int AW    = 3,
  parameter int DW    = 4,
  parameter int AF_TH = 6,
  parameter int AE_TH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  input  logic          pop,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic [AW-1:0] mem_addr_a,
  output logic          mem_rw_a,
  output logic [DW-1:0] mem_din_a,
  output logic [AW-1:0] mem_addr_b,
  output logic          mem_rw_b,
  input  logic [DW-1:0] mem_dout_b
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(2**AW);
  localparam logic [AW:0]   AF_C    = (AW+1)'(AF_TH);
  localparam logic [AW:0]   AE_C    = (AW+1)'(AE_TH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          wr_en;
  logic          rd_en;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  assign mem_addr_a = wr_ptr;
  assign mem_din_a  = data_in;
  assign mem_rw_a   = wr_en;
  assign mem_addr_b = rd_ptr;
  assign mem_rw_b   = 1'b0;
  assign data_out   = mem_dout_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      data_valid <= rd_en;
      // Error flags stay set until reset so software can see any past rejection.
      if (push & full)  overflow  <= 1'b1;
      if (pop & empty)  underflow <= 1'b1;
    end
  end

endmodule
